// File: rtl/pt_frame_ctrl.sv
// pt_frame_ctrl: serialises a 12-symbol tri-state code word into OOK chips.
// Each symbol is 32 chips and is followed, per frame, by a 128-chip sync bit.
// Each accepted word is sent REPEATS times back-to-back. tx_out is registered,
// so the first chip of a word appears in the cycle after it is accepted.
//
// Handshake: a word transfers on a rising clk edge where frame_valid=1 and
// frame_ready=1 (and abort=0). frame_ready is high exactly when the controller
// is idle, which includes the single done cycle. The requester may hold
// frame_valid high across transmissions. frame_data is latched when the word
// transfers and is ignored otherwise.
module pt_frame_ctrl #(
    parameter int unsigned REPEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [23:0] frame_data,
    input  logic        abort,
    output logic        frame_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CODE = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;

    localparam logic [4:0] REPS      = 5'(REPEATS);
    localparam logic [3:0] LAST_SYM  = 4'd11;
    localparam logic [6:0] LAST_CODE = 7'd31;
    localparam logic [6:0] LAST_SYNC = 7'd127;

    // Counters describe the chip currently shown on tx_out.
    logic [1:0]  state_q, state_d;
    logic [23:0] word_q,  word_d;
    logic [3:0]  sym_q,   sym_d;
    logic [6:0]  smp_q,   smp_d;
    logic [3:0]  rep_q,   rep_d;
    logic        tx_q,    tx_d;
    logic        done_q,  done_d;

    // Selects symbol idx of a word; symbol 0 sits in the top two bits.
    function automatic logic [1:0] symbol_at(input logic [23:0] w,
                                             input logic [3:0]  idx);
        logic [23:0] sh;
        sh = w << {idx, 1'b0};
        return sh[23:22];
    endfunction

    // Chip value of a code symbol. Each half is a high run then a low run.
    // First half: long (12) for one, short (4) otherwise.
    // Second half: short (4) for zero, long (12) for one and float.
    function automatic logic code_sample(input logic [1:0] sym,
                                         input logic [4:0] idx);
        logic       long_run;
        logic [3:0] off;
        off = idx[3:0];
        if (!idx[4]) begin
            long_run = (sym == 2'b01);
        end else begin
            long_run = (sym != 2'b00);
        end
        return long_run ? (off < 4'd12) : (off < 4'd4);
    endfunction

    // Sync bit: four chips of carrier, then silence for the rest of 128.
    function automatic logic sync_sample(input logic [6:0] idx);
        return idx < 7'd4;
    endfunction

    // Next-state, counter and next-chip computation.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sym_d   = sym_q;
        smp_d   = smp_q;
        rep_d   = rep_q;
        tx_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort wins over a word offered in the same cycle
                if (frame_valid && !abort) begin
                    word_d  = frame_data;
                    sym_d   = 4'd0;
                    smp_d   = 7'd0;
                    rep_d   = 4'd0;
                    state_d = ST_CODE;
                    tx_d    = code_sample(frame_data[23:22], 5'd0);
                end
            end

            ST_CODE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    sym_d   = 4'd0;
                    smp_d   = 7'd0;
                    rep_d   = 4'd0;
                end else if (smp_q == LAST_CODE) begin
                    smp_d = 7'd0;
                    if (sym_q == LAST_SYM) begin
                        sym_d   = 4'd0;
                        state_d = ST_SYNC;
                        tx_d    = sync_sample(7'd0);
                    end else begin
                        sym_d = sym_q + 4'd1;
                        tx_d  = code_sample(symbol_at(word_q, sym_q + 4'd1), 5'd0);
                    end
                end else begin
                    smp_d = smp_q + 7'd1;
                    tx_d  = code_sample(symbol_at(word_q, sym_q), smp_q[4:0] + 5'd1);
                end
            end

            ST_SYNC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    sym_d   = 4'd0;
                    smp_d   = 7'd0;
                    rep_d   = 4'd0;
                end else if (smp_q == LAST_SYNC) begin
                    smp_d = 7'd0;
                    sym_d = 4'd0;
                    if (({1'b0, rep_q} + 5'd1) < REPS) begin
                        rep_d   = rep_q + 4'd1;
                        state_d = ST_CODE;
                        tx_d    = code_sample(word_q[23:22], 5'd0);
                    end else begin
                        rep_d   = 4'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    smp_d = smp_q + 7'd1;
                    tx_d  = sync_sample(smp_q + 7'd1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sym_d   = 4'd0;
                smp_d   = 7'd0;
                rep_d   = 4'd0;
            end
        endcase
    end

    // State, latched word, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= 24'd0;
            sym_q   <= 4'd0;
            smp_q   <= 7'd0;
            rep_q   <= 4'd0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sym_q   <= sym_d;
            smp_q   <= smp_d;
            rep_q   <= rep_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign frame_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_out      = tx_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pt_frame_ctrl.sv
// Bench for pt_frame_ctrl: two instances (REPEATS=1 and REPEATS=4) checked
// every cycle against a position-based model, plus directed literal checks.
module tb_pt_frame_ctrl;

  logic        clk;
  logic        rst_n;

  logic        v1, a1, v4, a4;
  logic [23:0] d1, d4;
  logic        ready1, tx1, busy1, done1;
  logic        ready4, tx4, busy4, done4;
  logic [1:0]  st1, st4;

  int pass_cnt;
  int total_cnt;
  int fail_cnt;

  pt_frame_ctrl #(.REPEATS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .frame_valid(v1), .frame_data(d1), .abort(a1),
    .frame_ready(ready1), .tx_out(tx1), .busy(busy1), .done(done1),
    .dbg_state_o(st1)
  );

  pt_frame_ctrl #(.REPEATS(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .frame_valid(v4), .frame_data(d4), .abort(a4),
    .frame_ready(ready4), .tx_out(tx4), .busy(busy4), .done(done4),
    .dbg_state_o(st4)
  );

  // clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // A transmission is a linear run of 512*REPEATS chips; pos is the chip
  // currently on tx_out.
  typedef struct packed {
    bit          active;
    logic [23:0] word;
    int          pos;
    bit          done;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t mdl_step(mdl_t m, bit v, logic [23:0] d, bit a, int reps);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    if (!m.active) begin
      if (v && !a) begin
        n.active = 1'b1;
        n.word   = d;
        n.pos    = 0;
      end
    end else if (a) begin
      n.active = 1'b0;
    end else if (m.pos == 512 * reps - 1) begin
      n.active = 1'b0;
      n.done   = 1'b1;
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic bit mdl_tx(mdl_t m);
    int          fpos, s, sym;
    logic [23:0] w;
    logic [1:0]  code;
    if (!m.active) return 1'b0;
    fpos = m.pos % 512;
    if (fpos >= 384) return (fpos - 384) < 4;
    sym  = fpos / 32;
    s    = fpos % 32;
    w    = m.word;
    code = w[23 - 2 * sym -: 2];
    if (s < 16) return s < ((code == 2'b01) ? 12 : 4);
    return (s - 16) < ((code == 2'b00) ? 4 : 12);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0;
      m4 <= '0;
    end else begin
      m1 <= mdl_step(m1, v1, d1, a1, 1);
      m4 <= mdl_step(m4, v4, d4, a4, 4);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("r1_tx",    {31'd0, tx1},    {31'd0, mdl_tx(m1)});
      check("r1_busy",  {31'd0, busy1},  {31'd0, m1.active});
      check("r1_done",  {31'd0, done1},  {31'd0, m1.done});
      check("r1_ready", {31'd0, ready1}, {31'd0, !m1.active});
      check("r4_tx",    {31'd0, tx4},    {31'd0, mdl_tx(m4)});
      check("r4_busy",  {31'd0, busy4},  {31'd0, m4.active});
      check("r4_done",  {31'd0, done4},  {31'd0, m4.done});
      check("r4_ready", {31'd0, ready4}, {31'd0, !m4.active});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input int inst, input bit v, input logic [23:0] d, input bit a);
    if (inst == 1) begin
      v1 = v; d1 = d; a1 = a;
    end else begin
      v4 = v; d4 = d; a4 = a;
    end
  endtask

  function automatic bit o_tx(input int inst);
    return (inst == 1) ? tx1 : tx4;
  endfunction
  function automatic bit o_busy(input int inst);
    return (inst == 1) ? busy1 : busy4;
  endfunction
  function automatic bit o_done(input int inst);
    return (inst == 1) ? done1 : done4;
  endfunction

  // Send one word and measure the whole transmission with literal expectations.
  task automatic xmit(input int inst, input logic [23:0] data, input int exp_busy,
                      input int exp_ones, input logic [31:0] exp_first, input string name);
    int          k, ones, busyc;
    logic [31:0] first;
    bit          got;
    @(negedge clk);
    drive(inst, 1'b1, data, 1'b0);
    @(posedge clk);                                  // acceptance edge
    #2;
    drive(inst, 1'b0, 24'($urandom), 1'b0);          // later data must not matter
    k = 1; ones = 0; busyc = 0; first = '0; got = 1'b0;
    while (k <= exp_busy + 8) begin
      if (k <= 32) first = {first[30:0], o_tx(inst)};
      ones  += int'(o_tx(inst));
      busyc += int'(o_busy(inst));
      if (o_done(inst)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
      k++;
    end
    check({name, "_done_seen"},  {31'd0, got}, 32'd1);
    check({name, "_done_cycle"}, k,     exp_busy + 1);
    check({name, "_busy_cycles"}, busyc, exp_busy);
    check({name, "_ones"},       ones,  exp_ones);
    check({name, "_first32"},    first, exp_first);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bit got;
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0;
    v1 = 0; d1 = '0; a1 = 0;
    v4 = 0; d4 = '0; a4 = 0;

    // reset state
    #13;
    check("rst_r1_ready", {31'd0, ready1}, 32'd1);
    check("rst_r1_tx",    {31'd0, tx1},    32'd0);
    check("rst_r4_busy",  {31'd0, busy4},  32'd0);
    check("rst_r4_done",  {31'd0, done4},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // REPEATS=1, all-zero word: 100 carrier chips, done at T+513
    xmit(1, 24'h000000, 512, 100, 32'hF000F000, "r1_zero");
    // REPEATS=4 patterns
    xmit(4, 24'h555555, 2048, 1168, 32'hFFF0FFF0, "r4_one");
    xmit(4, 24'hAAAAAA, 2048, 784,  32'hF000FFF0, "r4_float10");
    xmit(4, 24'hFFFFFF, 2048, 784,  32'hF000FFF0, "r4_float11");

    // back-to-back with valid held high, then abort in frame 2 of word 2
    @(negedge clk);
    v4 = 1'b1; d4 = 24'h555555;
    @(posedge clk);
    #2;
    d4 = 24'hAAAAAA;
    k = 1; got = 1'b0;
    while (k <= 2100) begin
      if (done4) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
      k++;
    end
    check("b2b_done_seen",    {31'd0, got},    32'd1);
    check("b2b_done_cycle",   k,               32'd2049);
    check("b2b_ready_done",   {31'd0, ready4}, 32'd1);
    @(posedge clk);
    #2;
    v4 = 1'b0; d4 = 24'($urandom);
    check("b2b_busy_next",    {31'd0, busy4},  32'd1);
    check("b2b_first_sample", {31'd0, tx4},    32'd1);
    repeat (712) @(posedge clk);                     // chip 200 of frame 2
    #2;
    check("pre_abort_busy",   {31'd0, busy4},  32'd1);
    a4 = 1'b1;
    @(posedge clk);
    #2;
    a4 = 1'b0;
    check("abort_tx",    {31'd0, tx4},    32'd0);
    check("abort_busy",  {31'd0, busy4},  32'd0);
    check("abort_done",  {31'd0, done4},  32'd0);
    check("abort_ready", {31'd0, ready4}, 32'd1);
    got = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #2;
      if (done4) got = 1'b1;
    end
    check("abort_no_done", {31'd0, got}, 32'd0);

    // asynchronous reset during SYNC of frame 1
    @(negedge clk);
    v4 = 1'b1; d4 = 24'h000000;
    @(posedge clk);
    #2;
    v4 = 1'b0;
    repeat (400) @(posedge clk);                     // chip 400 (sync) now on tx_out
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tx",    {31'd0, tx4},    32'd0);
    check("arst_busy",  {31'd0, busy4},  32'd0);
    check("arst_done",  {31'd0, done4},  32'd0);
    check("arst_ready", {31'd0, ready4}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xmit(4, 24'h1B1B1B, 2048, 784, 32'hF000F000, "r4_after_rst");

    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pt_frame_ctrl.md
PT_FRAME_CTRL -- requirements
Module: pt_frame_ctrl

Interface
REQ-001 SHALL have parameter REPEATS, default 4, meaning the number of frame transmissions per accepted word (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; one clk period equals one output sample (chip).
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port frame_valid  input  1  requester has a code word available.
REQ-005 SHALL have port frame_data  input  24  twelve 2-bit tri-state symbols; [23:22] transmitted first; 00=zero, 01=one, 10=float, 11=float.
REQ-006 SHALL have port abort  input  1  synchronous request to stop transmission.
REQ-007 SHALL have port frame_ready  output  1  controller can accept a word this cycle.
REQ-008 SHALL have port tx_out  output  1  OOK modulator drive (1 = carrier on).
REQ-009 SHALL have port busy  output  1  transmission in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when all REPEATS frames have completed.

Function
REQ-011 SHALL implement states IDLE, CODE, SYNC.
REQ-012 SHALL assert frame_ready only in IDLE; frame_ready = (state==IDLE).
REQ-013 SHALL accept a word on a rising clk edge with frame_valid=1 and frame_ready=1: latch frame_data, set symbol index 0, sample index 0, repeat count 0, go to CODE.
REQ-014 SHALL drive the first sample of symbol 0 on tx_out in the first cycle after acceptance (latency 1); frame_data changes after acceptance have no effect.
REQ-015 SHALL emit each symbol as 32 samples, sample 0 first: zero = 4x1,12x0,4x1,12x0; one = 12x1,4x0,12x1,4x0; float = 4x1,12x0,12x1,4x0.
REQ-016 SHALL advance to the next symbol after sample 31 with no gap; after sample 31 of symbol 11, go to SYNC.
REQ-017 SHALL emit the sync bit in SYNC as 128 samples: 4x1 then 124x0.
REQ-018 SHALL, after sync sample 127, increment the repeat count; if count < REPEATS go to CODE at symbol 0, else go to IDLE.
REQ-019 SHALL make one frame exactly 512 cycles (384 code + 128 sync) and one full transmission 512*REPEATS cycles, repeats contiguous.
REQ-020 SHALL pulse done high for exactly the single cycle following the last sync sample, i.e. the first IDLE cycle; frame_ready is also high that cycle.
REQ-021 SHALL allow back-to-back words: a word with frame_valid=1 in the done cycle is accepted and its first sample appears the next cycle.
REQ-022 SHALL hold busy=1 in CODE and SYNC, 0 in IDLE.
REQ-023 SHALL drive tx_out=0 in IDLE.
REQ-024 SHALL, on abort=1 in CODE or SYNC, go to IDLE at that clk edge: tx_out=0 and busy=0 next cycle, done not pulsed; abort in IDLE is ignored, and abort has priority over acceptance in the same cycle.
REQ-025 SHALL register tx_out (no combinational path from inputs to tx_out).

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, tx_out=0, busy=0, done=0, frame_ready=1 after reset release, all counters 0, latched word 0.
REQ-027 SHALL, on rst_n asserted mid-transmission, abandon the frame immediately without a done pulse; the first edge after rst_n release may accept a new word.

Verification
REQ-028 SHALL cover: REPEATS=1, frame_data=24'h000000 accepted at cycle T -> tx_out from T+1 is 12 repetitions of 1111_0x12_1111_0x12 then 1111_0x124, done at T+513, busy low at T+513.
REQ-029 SHALL cover: frame_data=24'h555555 then 24'hAAAAAA, REPEATS=4 -> 12 one-patterns per frame and 12 float-patterns respectively, 2048 busy cycles each, one done pulse each.
REQ-030 SHALL cover: symbol 11 (frame_data=24'hFFFFFF) -> output identical to 24'hAAAAAA.
REQ-031 SHALL cover: frame_valid held high continuously -> second word accepted in done cycle, tx_out first sample of word 2 one cycle later, no idle gap beyond that cycle.
REQ-032 SHALL cover: abort at cycle 200 of frame 2 -> tx_out=0, busy=0 next cycle, no done, frame_ready=1.
REQ-033 SHALL cover: rst_n pulsed low asynchronously (between edges) during SYNC -> outputs reset immediately, no done, next word transmits from symbol 0, sample 0.
